intersection_scheduler: RTL and testbench
=========================================

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameter MIN_HGRN, default 4: minimum highway-green dwell, in clock cycles (range 1..15).
REQ-002 Parameter Y2RDELAY, default 3: yellow dwell, in cycles (range 1..15).
REQ-003 Parameter R2GDELAY, default 2: all-red dwell, in cycles (range 1..15).
REQ-004 Parameter MAX_CGRN, default 8: maximum country-green dwell, in cycles (range 1..15).
REQ-005 Parameter WALKTIME, default 5: pedestrian-walk dwell, in cycles (range 1..15).
REQ-006 clock  in  1  sole clock; all state updates occur on its rising edge.
REQ-007 clear_n  in  1  reset, synchronous and active-low.
REQ-008 x  in  1  level input; 1 = car waiting on, or occupying, the country road.
REQ-009 ped_req  in  1  pedestrian button, one or more cycles high.
REQ-010 highway  out  2  highway lamp: RED=0, YELLOW=1, GREEN=2.
REQ-011 country  out  2  country-road lamp, using the same encoding as highway.
REQ-012 walk  out  1  pedestrian walk lamp.
REQ-013 ped_pend  out  1  1 = a pedestrian request is latched and not yet served.
REQ-014 phase  out  3  current state code, for debug.

Function
REQ-015 The FSM SHALL have six states: HG=0, HY=1, AR=2, CG=3, CY=4, WK=5; codes 6 and 7 SHALL go to HG on the next edge.
REQ-016 Lamp outputs SHALL be Moore-decoded from the state register as follows:
- HG: highway GREEN, country RED
- HY: highway YELLOW, country RED
- AR: highway RED, country RED
- CG: highway RED, country GREEN
- CY: highway RED, country YELLOW
- WK: highway RED, country RED, walk=1
- walk=0 in every other state.
REQ-017 A 4-bit dwell timer tmr SHALL load 0 on every state change and otherwise increment, saturating at 15.
REQ-018 HG -> HY when tmr >= MIN_HGRN-1 and (x or ped_pend); otherwise HG holds indefinitely.
REQ-019 HY -> AR when tmr == Y2RDELAY-1, so HY lasts exactly Y2RDELAY cycles.
REQ-020 AR exit when tmr == R2GDELAY-1, with pedestrian priority:
- to WK if ped_pend
- else to CG if x
- else to HG.
REQ-021 CG -> CY when x == 0 or tmr == MAX_CGRN-1, whichever comes first.
REQ-022 CY -> HG when tmr == Y2RDELAY-1.
REQ-023 WK -> HG when tmr == WALKTIME-1.
REQ-024 ped_pend SHALL set on any cycle with ped_req=1.
REQ-025 ped_pend SHALL clear on the edge that enters WK; a ped_req in that same cycle is absorbed (clear wins).
REQ-026 ped_req pulses arriving during WK SHALL set ped_pend for a later service.
REQ-027 Highway and country SHALL never both be non-RED, and walk=1 SHALL imply both are RED; the bench asserts this every cycle.
REQ-028 x and ped_req SHALL be sampled only at rising edges; behaviour for glitches between edges is not specified.

Reset
REQ-029 When clear_n=0 at a rising edge, the block SHALL load state=HG, tmr=0 and ped_pend=0, overriding all other inputs.
REQ-030 After reset the outputs SHALL be highway=GREEN(2), country=RED(0), walk=0, ped_pend=0, phase=0.
REQ-031 Reset asserted in any state, including mid-yellow or mid-walk, SHALL give HG on the next edge with no intermediate yellow.

Structure
REQ-032 Shared package tc_pkg SHALL hold the lamp encodings RED/YELLOW/GREEN, the state codes HG..WK, and the default delay constants.
REQ-033 The dwell timer SHALL be a separate sub-module, phase_timer, with inputs clock, clear_n and restart and a 4-bit output count.
REQ-034 The next-state logic and the output decode SHALL be purely combinational, with no procedural delay waiting on clock edges.

Verification
REQ-035 Reset, then hold x=0 and ped_req=0 for 50 cycles -> state stays HG for all 50 cycles; highway=2, country=0.
REQ-036 With defaults, raise x at cycle 1 after reset and hold it -> required timeline:
- HG for cycles 0-3
- HY for 4-6
- AR for 7-8
- CG for 9-16 (max reached)
- CY for 17-19
- HG from cycle 20.
REQ-037 Pulse ped_req for 1 cycle with x=0 -> ped_pend=1 until the edge entering WK; WK lasts 5 cycles with walk=1; then HG.
REQ-038 Assert ped_req and x together -> AR goes to WK (not CG); the CG service follows on the next HG -> HY cycle.
REQ-039 Assert clear_n=0 for one cycle during CY, and separately during WK -> next cycle is HG, tmr=0, ped_pend=0, walk=0.
REQ-040 Drop x after 2 cycles of CG -> CY entered on the 3rd CG cycle edge; the REQ-027 safety assertion holds for the whole run.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared encodings and default dwell times for the intersection controller.
package tc_pkg;

    localparam int unsigned LAMP_W  = 2;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned TMR_W   = 4;

    localparam int unsigned DEF_MIN_HGRN = 4;
    localparam int unsigned DEF_Y2RDELAY = 3;
    localparam int unsigned DEF_R2GDELAY = 2;
    localparam int unsigned DEF_MAX_CGRN = 8;
    localparam int unsigned DEF_WALKTIME = 5;

    typedef enum logic [LAMP_W-1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_e;

    typedef enum logic [STATE_W-1:0] {
        HG = 3'd0,
        HY = 3'd1,
        AR = 3'd2,
        CG = 3'd3,
        CY = 3'd4,
        WK = 3'd5
    } state_e;

endpackage

// File: rtl/phase_timer.sv
// Per-phase dwell counter: zeroed on restart or reset, otherwise counts up and saturates.
module phase_timer
    import tc_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             restart,
    output logic [TMR_W-1:0] count
);

    localparam logic [TMR_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clock) begin
        if (!clear_n || restart) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + TMR_W'(1);
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Highway / country-road / pedestrian signal sequencer with registered lamp outputs.
module intersection_scheduler
    import tc_pkg::*;
#(
    parameter int unsigned MIN_HGRN = DEF_MIN_HGRN,
    parameter int unsigned Y2RDELAY = DEF_Y2RDELAY,
    parameter int unsigned R2GDELAY = DEF_R2GDELAY,
    parameter int unsigned MAX_CGRN = DEF_MAX_CGRN,
    parameter int unsigned WALKTIME = DEF_WALKTIME
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               x,
    input  logic               ped_req,
    output logic [LAMP_W-1:0]  highway,
    output logic [LAMP_W-1:0]  country,
    output logic               walk,
    output logic               ped_pend,
    output logic [STATE_W-1:0] phase
);

    localparam logic [TMR_W-1:0] HG_MIN = TMR_W'(MIN_HGRN - 1);
    localparam logic [TMR_W-1:0] Y_END  = TMR_W'(Y2RDELAY - 1);
    localparam logic [TMR_W-1:0] R_END  = TMR_W'(R2GDELAY - 1);
    localparam logic [TMR_W-1:0] CG_END = TMR_W'(MAX_CGRN - 1);
    localparam logic [TMR_W-1:0] WK_END = TMR_W'(WALKTIME - 1);

    state_e            state;
    state_e            state_next;
    logic [TMR_W-1:0]  tmr;
    logic              restart_c;
    logic              pend_next;
    lamp_e             hw_next;
    lamp_e             cty_next;
    logic              walk_next;

    phase_timer u_timer (
        .clock   (clock),
        .clear_n (clear_n),
        .restart (restart_c),
        .count   (tmr)
    );

    // State, pending request and lamp registers; lamps are the decode of the state being entered.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state    <= HG;
            ped_pend <= 1'b0;
            highway  <= GREEN;
            country  <= RED;
            walk     <= 1'b0;
        end else begin
            state    <= state_next;
            ped_pend <= pend_next;
            highway  <= hw_next;
            country  <= cty_next;
            walk     <= walk_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HG: if (tmr >= HG_MIN && (x || ped_pend)) state_next = HY;
            HY: if (tmr == Y_END) state_next = AR;
            AR: begin
                if (tmr == R_END) begin
                    if (ped_pend)  state_next = WK;
                    else if (x)    state_next = CG;
                    else           state_next = HG;
                end
            end
            CG: if (!x || tmr == CG_END) state_next = CY;
            CY: if (tmr == Y_END) state_next = HG;
            WK: if (tmr == WK_END) state_next = HG;
            default: state_next = HG;
        endcase
    end

    // Entering WK serves the request; a press in that same cycle is absorbed.
    always_comb begin
        restart_c = (state_next != state);
        pend_next = ped_pend | ped_req;
        if (state_next == WK && state != WK) pend_next = 1'b0;
    end

    always_comb begin
        hw_next   = RED;
        cty_next  = RED;
        walk_next = 1'b0;
        case (state_next)
            HG:      hw_next   = GREEN;
            HY:      hw_next   = YELLOW;
            CG:      cty_next  = GREEN;
            CY:      cty_next  = YELLOW;
            WK:      walk_next = 1'b1;
            default: hw_next   = RED;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed table-driven bench for intersection_scheduler with a per-cycle lamp safety monitor.
module tb_intersection_scheduler;

    logic       clock;
    logic       clear_n;
    logic       x;
    logic       ped_req;
    logic [1:0] highway;
    logic [1:0] country;
    logic       walk;
    logic       ped_pend;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;
    bit monitor_on = 0;

    localparam int P_HG = 0, P_HY = 1, P_AR = 2, P_CG = 3, P_CY = 4, P_WK = 5;

    typedef struct {
        bit rn;
        bit xi;
        bit pr;
        int ph;
        bit pd;
    } vec_t;

    vec_t vecs[$];

    intersection_scheduler dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .x        (x),
        .ped_req  (ped_req),
        .highway  (highway),
        .country  (country),
        .walk     (walk),
        .ped_pend (ped_pend),
        .phase    (phase)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input bit rn, input bit xi, input bit pr, input int ph, input bit pd,
                       input int reps);
        vec_t v;
        v.rn = rn; v.xi = xi; v.pr = pr; v.ph = ph; v.pd = pd;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    function automatic int exp_hw(input int ph);
        case (ph)
            P_HG:    return 2;
            P_HY:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_cty(input int ph);
        case (ph)
            P_CG:    return 2;
            P_CY:    return 1;
            default: return 0;
        endcase
    endfunction

    // Lamp safety: never two non-red roads, and walk only with all red.
    always @(negedge clock) begin
        if (monitor_on) begin
            n_checks++;
            if (highway != 2'd0 && country != 2'd0) begin
                n_fail++;
                $display("FAIL safety_roads: highway=%0d country=%0d required one RED", highway, country);
            end
            if (walk && (highway != 2'd0 || country != 2'd0)) begin
                n_fail++;
                $display("FAIL safety_walk: walk=1 highway=%0d country=%0d required both RED", highway, country);
            end
        end
    end

    initial begin
        clear_n = 1'b0;
        x       = 1'b0;
        ped_req = 1'b0;

        // Idle hold: 50 cycles of green highway.
        step();
        clear_n = 1'b1;
        monitor_on = 1;
        check("rst_phase", int'(phase), P_HG);
        check("rst_highway", int'(highway), 2);
        check("rst_country", int'(country), 0);
        check("rst_walk", int'(walk), 0);
        check("rst_pend", int'(ped_pend), 0);
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_phase", int'(phase), P_HG);
            check("idle_highway", int'(highway), 2);
            check("idle_country", int'(country), 0);
        end

        // Car timeline with defaults: x raised during cycle 1 and held.
        add(0, 0, 0, P_HG, 0, 1);
        add(1, 0, 0, P_HG, 0, 1);
        add(1, 1, 0, P_HG, 0, 2);
        add(1, 1, 0, P_HY, 0, 3);
        add(1, 1, 0, P_AR, 0, 2);
        add(1, 1, 0, P_CG, 0, 8);
        add(1, 1, 0, P_CY, 0, 3);
        add(1, 1, 0, P_HG, 0, 1);
        // Pedestrian only; press on the WK-entry edge is absorbed, press during WK re-arms.
        add(0, 0, 0, P_HG, 0, 1);
        add(1, 0, 1, P_HG, 1, 1);
        add(1, 0, 0, P_HG, 1, 2);
        add(1, 0, 0, P_HY, 1, 3);
        add(1, 0, 0, P_AR, 1, 2);
        add(1, 0, 1, P_WK, 0, 1);
        add(1, 0, 0, P_WK, 0, 1);
        add(1, 0, 1, P_WK, 1, 1);
        add(1, 0, 0, P_WK, 1, 2);
        add(1, 0, 0, P_HG, 1, 4);
        add(1, 0, 0, P_HY, 1, 1);
        // Car and pedestrian together: walk first, country green on the next cycle round.
        add(0, 0, 0, P_HG, 0, 1);
        add(1, 1, 1, P_HG, 1, 1);
        add(1, 1, 0, P_HG, 1, 2);
        add(1, 1, 0, P_HY, 1, 3);
        add(1, 1, 0, P_AR, 1, 2);
        add(1, 1, 0, P_WK, 0, 5);
        add(1, 1, 0, P_HG, 0, 4);
        add(1, 1, 0, P_HY, 0, 3);
        add(1, 1, 0, P_AR, 0, 2);
        add(1, 1, 0, P_CG, 0, 1);
        // Car leaves on the third CG cycle, then reset lands mid-yellow.
        add(0, 0, 0, P_HG, 0, 1);
        add(1, 1, 0, P_HG, 0, 3);
        add(1, 1, 0, P_HY, 0, 3);
        add(1, 1, 0, P_AR, 0, 2);
        add(1, 1, 0, P_CG, 0, 3);
        add(1, 0, 0, P_CY, 0, 1);
        add(0, 0, 0, P_HG, 0, 1);
        add(1, 0, 0, P_HG, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            clear_n = vecs[i].rn;
            x       = vecs[i].xi;
            ped_req = vecs[i].pr;
            step();
            check($sformatf("v%0d_phase", i), int'(phase), vecs[i].ph);
            check($sformatf("v%0d_highway", i), int'(highway), exp_hw(vecs[i].ph));
            check($sformatf("v%0d_country", i), int'(country), exp_cty(vecs[i].ph));
            check($sformatf("v%0d_walk", i), int'(walk), (vecs[i].ph == P_WK) ? 1 : 0);
            check($sformatf("v%0d_pend", i), int'(ped_pend), int'(vecs[i].pd));
            if (!vecs[i].rn) check($sformatf("v%0d_tmr", i), int'(dut.u_timer.count), 0);
        end

        // Reset asserted in the middle of a walk.
        clear_n = 1'b0; x = 1'b0; ped_req = 1'b0;
        step();
        clear_n = 1'b1;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        for (int i = 0; i < 30 && phase != 3'(P_WK); i++) step();
        check("wk_reached", int'(phase), P_WK);
        step();
        check("wk_mid_walk", int'(walk), 1);
        clear_n = 1'b0;
        ped_req = 1'b1;
        step();
        check("wkrst_phase", int'(phase), P_HG);
        check("wkrst_walk", int'(walk), 0);
        check("wkrst_pend", int'(ped_pend), 0);
        check("wkrst_tmr", int'(dut.u_timer.count), 0);
        check("wkrst_highway", int'(highway), 2);
        clear_n = 1'b1;
        ped_req = 1'b0;
        step();
        check("wkrst_after_phase", int'(phase), P_HG);
        check("wkrst_after_tmr", int'(dut.u_timer.count), 1);
        check("wkrst_after_pend", int'(ped_pend), 0);

        monitor_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
